aes_enc_iter: RTL and testbench
===============================

# aes_enc_iter

Parametrised iterative AES encryption core: accepts one 128-bit plaintext block per transaction over a valid/ready handshake and applies the initial AddRoundKey plus NR cipher rounds. RPC rounds are computed per clock using combinational SubBytes/ShiftRows/MixColumns/AddRoundKey logic. The final round omits MixColumns. It returns the ciphertext over a second valid/ready handshake. It sits between the framing logic and the transmit path and replaces chains of single-round stages with one handshaked, flushable engine.

## Interface

- NR, 10: number of cipher rounds (10/12/14); legal range 1..14.
- RPC, 1: rounds evaluated per clock (1 or 2); NR % RPC == 0 is required, otherwise elaboration error.
- clk  in  1  clock; all state changes on rising edge.
- resetn  in  1  asynchronous, active-high reset (asserted = 1).
- flush  in  1  synchronous abort; drops any block in flight.
- in_valid  in  1  in_data valid.
- in_ready  out  1  core can accept in_data this cycle.
- in_data  in  128  plaintext; bits [127:120] = s(0,0), [119:112] = s(1,0), column-major per FIPS-197.
- keys  in  128*(NR+1)  expanded round keys; round key r at bits [128*r+127:128*r], same byte order as in_data. Must be held stable from accept until out handshake.
- out_valid  out  1  out_data holds a finished ciphertext.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  128  ciphertext, same byte order.

## Operation

- States: IDLE, RUN, DONE. The round counter rnd is $clog2(NR+1) bits wide. The state register st is 128 bits.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: st <= in_data ^ key[0], rnd <= 1, go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle applies rounds rnd .. rnd+RPC-1 in sequence to st.
  - Round r = SubBytes → ShiftRows → MixColumns (skipped when r == NR) → XOR key[r].
  - rnd <= rnd + RPC.
  - When the cycle's last applied round equals NR: out_data <= result, out_valid <= 1, go to DONE.
- DONE:
  - out_valid = 1; out_data stable until handshake.
  - in_ready = out_ready, so a new block may be accepted in the same cycle as the output handshake.
  - out_valid & out_ready without a new accept: out_valid <= 0, go to IDLE.
  - Output handshake plus simultaneous accept: out_valid <= 0, load new st, rnd <= 1, go to RUN.
  - out_ready = 0: hold indefinitely; in_ready = 0.
- flush = 1 in any state:
  - Next state IDLE, out_valid <= 0, rnd <= 0.
  - Overrides any handshake in the same cycle; an in_valid that cycle is not accepted.
- SubBytes: FIPS-197 S-box, 16·RPC combinational instances; no clocked S-box.
- MixColumns: GF(2^8) arithmetic, xtime with reduction polynomial 0x1B; all arithmetic mod 2^8, no carries.
- keys are read live each RUN cycle. If keys change mid-block the result is undefined, but no hang occurs.

## Timing

- Reset (resetn = 1, async):
  - State IDLE, st = 0, rnd = 0, out_valid = 0, out_data = 128'h0.
  - in_ready is forced to 0 while resetn = 1 and returns to 1 in the first cycle after deassertion.
- Latency: accept at edge E; out_valid = 1 after edge E + NR/RPC (NR=10, RPC=1 → 10 cycles; RPC=2 → 5 cycles).
- Throughput: one block per NR/RPC + 1 cycles when out_ready is held 1. The accept coincides with the previous output handshake, so DONE lasts one cycle.
- Reset asserted mid-RUN or in DONE: the block is lost; outputs take their reset values immediately (asynchronously).
- in_valid while in_ready = 0: ignored; the source must hold data (standard valid/ready; the core never drops an accepted block except on flush/reset).
- out_data changes only on the edge entering DONE, or on reset.

## Test plan

- FIPS-197 App. B, NR=10, RPC=1:
  - Stimulus: plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c (bench-expanded).
  - Required: out_data = 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after accept.
- FIPS-197 App. C.1 with RPC=2:
  - Stimulus: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f.
  - Required: out_data = 69c4e0d86a7b0430d8cdb78070b4c55a after 5 cycles; repeat with NR=14 and the C.3 256-bit key → 8ea2b7ca516745bfeafc49904b496089 after 14/7 cycles.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 20 cycles in DONE.
  - Required: out_valid and out_data stable, in_ready = 0; on out_ready = 1 exactly one handshake occurs.
- Back-to-back:
  - Stimulus: in_valid and out_ready held 1 with 4 App. B/C.1 blocks alternating.
  - Required: each block's ciphertext is correct and in order; one block per 11 cycles (RPC=1).
- Flush:
  - Stimulus: assert flush at round 5 of a block, and separately in DONE while out_ready = 1 and in_valid = 1.
  - Required: next cycle IDLE, out_valid = 0, no handshake and no accept in the flush cycle; the subsequent block encrypts correctly.
- Async reset:
  - Stimulus: pulse resetn mid-RUN, between clock edges.
  - Required: out_valid = 0 and out_data = 0 immediately, in_ready = 0 during reset and 1 the cycle after release; a fresh block then matches App. B.

Source files
------------

// File: rtl/aes_enc_iter.sv
// aes_enc_iter: iterative AES-128/192/256 encryption engine, RPC rounds per clock, valid/ready in and out
module aes_enc_iter #(
  parameter int NR = 10,
  parameter int RPC = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          in_data,
  input  logic [128*(NR+1)-1:0] keys,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          out_data
);
  localparam int RW = $clog2(NR + 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  // S-box entry x lives at bits [8*(255-x) +: 8], hence the ~b lookup below
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  if (NR < 1 || NR > 14 || (RPC != 1 && RPC != 2) || NR % RPC != 0) begin : g_bad
    $error("aes_enc_iter: illegal NR/RPC combination");
  end

  function automatic logic [7:0] sub(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xt(a0 ^ a1) ^ a1 ^ a2 ^ a3, xt(a1 ^ a2) ^ a2 ^ a3 ^ a0,
            xt(a2 ^ a3) ^ a3 ^ a0 ^ a1, xt(a3 ^ a0) ^ a0 ^ a1 ^ a2};
  endfunction

  // byte i sits at row i%4, column i/4; ShiftRows pulls from column (c+r)%4
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [127:0] t;
    for (int i = 0; i < 16; i++) t[127-8*i -: 8] = sub(s[127-8*(i%4+4*((i/4+i%4)%4)) -: 8]);
    for (int c = 0; c < 4; c++) t[127-32*c -: 32] = last ? t[127-32*c -: 32] : mixcol(t[127-32*c -: 32]);
    return t ^ k;
  endfunction

  logic [1:0] state;
  logic [RW-1:0] rnd;
  logic [127:0] st;
  logic [127:0] chain [RPC+1];
  logic fin;

  always_comb begin
    chain[0] = st;
    for (int j = 0; j < RPC; j++) chain[j+1] = aes_round(chain[j], keys[128*(int'(rnd)+j) +: 128], int'(rnd) + j == NR);
    fin = int'(rnd) + RPC - 1 == NR;
  end

  assign in_ready = !resetn && (state == IDLE || (state == DONE && out_ready));

  always_ff @(posedge clk or posedge resetn)
    if (resetn) begin
      state <= IDLE;
      st <= '0;
      rnd <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (flush) begin
      state <= IDLE;
      rnd <= '0;
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      state <= RUN;
      st <= in_data ^ keys[127:0];
      rnd <= RW'(1);
      out_valid <= 1'b0;
    end else if (state == RUN) begin
      st <= chain[RPC];
      rnd <= rnd + RW'(RPC);
      if (fin) begin
        state <= DONE;
        out_data <= chain[RPC];
        out_valid <= 1'b1;
      end
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
      out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_aes_enc_iter.sv
// tb_aes_enc_iter: three engine configurations checked against FIPS-197 vectors and a byte-matrix AES model
module tb_aes_enc_iter;
  localparam int NRS [3] = '{10, 10, 14};
  localparam int RPCS [3] = '{1, 2, 2};

  typedef struct {
    int d;
    logic [127:0] pt;
    logic [255:0] key;
    int nk;
    logic [127:0] ct;
    int stall;
  } vec_t;

  logic clk, rst, flush;
  logic iv [3], ir [3], ov [3], ordy [3];
  logic [127:0] din [3], dout [3];
  logic [1919:0] rk [3];
  logic [7:0] sb [256];
  int checks, failures;

  localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] K_B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_enc_iter #(.NR(10), .RPC(1)) da (.clk(clk), .resetn(rst), .flush(flush), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(din[0]), .keys(rk[0][1407:0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(dout[0]));
  aes_enc_iter #(.NR(10), .RPC(2)) db (.clk(clk), .resetn(rst), .flush(flush), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(din[1]), .keys(rk[1][1407:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(dout[1]));
  aes_enc_iter #(.NR(14), .RPC(2)) dc (.clk(clk), .resetn(rst), .flush(flush), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(din[2]), .keys(rk[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(dout[2]));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 0;
      for (int b = 1; b < 256; b++) if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1919:0] o;
    rc = 8'h01;
    o = '0;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gm(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
      o[128*(i/4) + 32*(3-i%4) +: 32] = w[i];
    end
    return o;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt, input logic [1919:0] k, input int nr);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [7:0] m [4];
    logic [7:0] v;
    logic [127:0] o;
    m = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) s[r][c] = pt[127-8*(r+4*c) -: 8] ^ k[127-8*(r+4*c) -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) t[r][c] = sb[s[r][(c+r)%4]];
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
        v = t[r][c];
        if (rd != nr) begin
          v = 0;
          for (int q = 0; q < 4; q++) v ^= gm(m[(q-r+4)%4], t[q][c]);
        end
        s[r][c] = v ^ k[128*rd + 127 - 8*(r+4*c) -: 8];
      end
    end
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) o[127-8*(r+4*c) -: 8] = s[r][c];
    return o;
  endfunction

  task automatic check(input logic [127:0] act, input logic [127:0] exp, input string nm);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input int d);
    int cyc;
    cyc = 0;
    while (!ir[d] && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check(128'(ir[d]), 128'(1), "in_ready_timeout");
  endtask

  // one full transaction on engine d; stall = cycles out_ready is held low once out_valid rises
  task automatic xfer(input int d, input logic [127:0] pt, input logic [1919:0] keys, input logic [127:0] exp, input int stall);
    int cyc;
    bit bad;
    rk[d] = keys;
    ordy[d] = (stall == 0);
    wait_ready(d);
    din[d] = pt;
    iv[d] = 1;
    @(negedge clk);
    iv[d] = 0;
    din[d] = {$urandom(), $urandom(), $urandom(), $urandom()};
    cyc = 0;
    while (!ov[d] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check(128'(cyc), 128'(NRS[d] / RPCS[d]), "latency");
    check(dout[d], exp, "ciphertext");
    bad = 0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!ov[d] || dout[d] !== exp || ir[d]) bad = 1;
    end
    if (stall > 0) check(128'(bad), 128'(0), "backpressure_hold");
    ordy[d] = 1;
    @(negedge clk);
    check(128'(ov[d]), 128'(0), "single_handshake");
  endtask

  vec_t vecs [7];
  logic [127:0] bpt [4], bexp [4];
  logic [1919:0] bk [4];

  initial begin
    int cyc, k, last, d, nk;
    bit bad;
    logic [255:0] key;
    logic [127:0] pt;
    logic [1919:0] ks;
    vecs[0] = '{0, PT_B, K_B, 4, CT_B, 0};
    vecs[1] = '{1, PT_C, K_C1, 4, CT_C1, 0};
    vecs[2] = '{2, PT_C, K_C3, 8, CT_C3, 0};
    vecs[3] = '{0, PT_C, K_C1, 4, CT_C1, 1};
    vecs[4] = '{1, PT_B, K_B, 4, CT_B, 3};
    vecs[5] = '{0, PT_B, K_B, 4, CT_B, 20};
    vecs[6] = '{2, PT_C, K_C3, 8, CT_C3, 20};
    checks = 0;
    failures = 0;
    build_sbox();
    rst = 1;
    flush = 0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 0;
      ordy[i] = 0;
      din[i] = '0;
      rk[i] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check(128'(ov[i]), 128'(0), "reset_out_valid");
      check(dout[i], 128'h0, "reset_out_data");
      check(128'(ir[i]), 128'(0), "reset_in_ready");
    end
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check(128'(ir[i]), 128'(1), "post_reset_in_ready");

    for (int v = 0; v < 7; v++) xfer(vecs[v].d, vecs[v].pt, expand(vecs[v].key, vecs[v].nk, NRS[vecs[v].d]), vecs[v].ct, vecs[v].stall);

    for (int n = 0; n < 18; n++) begin
      d = n % 3;
      nk = (d == 2) ? 8 : 4;
      key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      ks = expand(key, nk, NRS[d]);
      xfer(d, pt, ks, enc(pt, ks, NRS[d]), $urandom_range(0, 3));
    end

    // back-to-back on the single-round engine, alternating App. B and C.1
    for (int i = 0; i < 4; i++) begin
      bpt[i] = (i % 2 == 0) ? PT_B : PT_C;
      bk[i] = expand((i % 2 == 0) ? K_B : K_C1, 4, 10);
      bexp[i] = (i % 2 == 0) ? CT_B : CT_C1;
    end
    ordy[0] = 1;
    wait_ready(0);
    din[0] = bpt[0];
    rk[0] = bk[0];
    iv[0] = 1;
    k = 0;
    last = 0;
    cyc = 0;
    while (k < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (ov[0]) begin
        check(dout[0], bexp[k], "b2b_ciphertext");
        if (k > 0) check(128'(cyc - last), 128'(11), "b2b_period");
        last = cyc;
        k++;
        if (k < 4) begin
          din[0] = bpt[k];
          rk[0] = bk[k];
        end else iv[0] = 0;
      end
    end
    check(128'(k), 128'(4), "b2b_count");
    @(negedge clk);
    check(128'(ov[0]), 128'(0), "b2b_drain");

    // flush at round 5 with a competing in_valid
    rk[0] = expand(K_B, 4, 10);
    ordy[0] = 1;
    wait_ready(0);
    din[0] = PT_B;
    iv[0] = 1;
    @(negedge clk);
    iv[0] = 0;
    repeat (4) @(negedge clk);
    flush = 1;
    iv[0] = 1;
    @(negedge clk);
    check(128'(ir[0]), 128'(1), "flush_run_idle");
    check(128'(ov[0]), 128'(0), "flush_run_out_valid");
    flush = 0;
    iv[0] = 0;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov[0]) bad = 1;
    end
    check(128'(bad), 128'(0), "flush_block_dropped");
    xfer(0, PT_B, expand(K_B, 4, 10), CT_B, 0);

    // flush in DONE while out_ready and in_valid are both high
    ordy[0] = 0;
    wait_ready(0);
    din[0] = PT_B;
    iv[0] = 1;
    @(negedge clk);
    iv[0] = 0;
    cyc = 0;
    while (!ov[0] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check(dout[0], CT_B, "flush_done_pre");
    ordy[0] = 1;
    iv[0] = 1;
    din[0] = PT_C;
    rk[0] = expand(K_C1, 4, 10);
    flush = 1;
    @(negedge clk);
    check(128'(ov[0]), 128'(0), "flush_done_out_valid");
    check(128'(ir[0]), 128'(1), "flush_done_no_accept");
    flush = 0;
    iv[0] = 0;
    xfer(0, PT_C, expand(K_C1, 4, 10), CT_C1, 0);

    // asynchronous reset between edges in the middle of a block
    rk[0] = expand(K_B, 4, 10);
    ordy[0] = 1;
    wait_ready(0);
    din[0] = PT_B;
    iv[0] = 1;
    @(negedge clk);
    iv[0] = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    check(128'(ov[0]), 128'(0), "async_out_valid");
    check(dout[0], 128'h0, "async_out_data");
    check(128'(ir[0]), 128'(0), "async_in_ready");
    @(negedge clk);
    check(128'(ir[0]), 128'(0), "reset_held_in_ready");
    #2 rst = 0;
    @(negedge clk);
    check(128'(ir[0]), 128'(1), "reset_release_in_ready");
    xfer(0, PT_B, expand(K_B, 4, 10), CT_B, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
